// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields (R/I/S/B) into 32-bit words and writes
// them to consecutive instruction-memory word addresses starting at BASE_ADDR.
// Ports: clk/rst (async active-low)/clr; in_* field stream (valid/ready, in_last);
//        mem_we/mem_ready/mem_addr/mem_wdata write port; done; err (sticky).
// Optional: define ENC_CHECK_EN to flag non-32-bit opcodes and odd B-type offsets on err.

// fifo: small generic circular buffer with occupancy count and synchronous flush.
// Latency: a pushed entry is visible on pop_dat the cycle after the push (if empty).
// Backpressure: full is exposed to the caller; push while full must not be issued.
module fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_rdy,
  output logic [W-1:0]           pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_rdy)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !clr) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr[AW-1:0]];
endmodule

// instr_encoder: field bundle -> encoded word -> FIFO -> instruction memory writes.
// Latency: accepted bundle drives mem_we/mem_wdata the cycle after acceptance (empty FIFO).
// Backpressure: mem_ready low holds the head write; in_ready drops when full or after in_last.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [1:0]  in_fmt,
  input  logic [6:0]  in_op,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [12:0] in_imm,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] enc_word;
  logic [31:0] head_dat;
  logic [31:0] addr_q;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic        accept, push, pop;

  // clr wins over a same-cycle accept or write completion.
  assign accept = in_valid && in_ready;
  assign push   = accept && !clr;
  assign pop    = mem_we && mem_ready && !clr;

  always_comb begin
    enc_word = '0;
    case (in_fmt)
      2'b00:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
      2'b01:   enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
      2'b10:   enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_op};
      default: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
    endcase
  end

  fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push_vld (push),
    .push_dat (enc_word),
    .pop_rdy  (pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DRAIN : LOAD;
      LOAD:    if (accept && in_last) state_d = DRAIN;
      // No pushes in DRAIN, so popping the only entry empties the FIFO.
      DRAIN:   if (pop && fifo_count == (AW+1)'(1)) state_d = FIN;
      default: state_d = FIN;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     addr_q <= BASE_ADDR;
    else if (clr) addr_q <= BASE_ADDR;
    else if (pop) addr_q <= addr_q + 32'd4;
  end

  assign in_ready  = !fifo_full && (state_q == IDLE || state_q == LOAD);
  assign mem_we    = !fifo_empty && (state_q != FIN);
  // Gate the head so stale storage never shows after reset or a flush.
  assign mem_wdata = fifo_empty ? 32'h0 : head_dat;
  assign mem_addr  = addr_q;
  assign done      = (state_q == FIN);

`ifdef ENC_CHECK_EN
  logic err_q;
  logic enc_bad;

  assign enc_bad = (in_op[1:0] != 2'b11) || (in_fmt == 2'b10 && in_imm[0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 err_q <= 1'b0;
    else if (clr)             err_q <= 1'b0;
    else if (push && enc_bad) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  // imm[0] is never encoded; only the optional check looks at it.
  logic unused_imm0;
  assign unused_imm0 = in_imm[0];
  assign err         = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a
// field-arithmetic reference encoder and an in-order write scoreboard.
module tb_instr_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, in_last, mem_we, mem_ready, done, err;
  logic [1:0]  in_fmt;
  logic [6:0]  in_op, in_funct7;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;
  logic [31:0] mem_addr, mem_wdata;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  typedef struct packed {
    logic        last;
    logic [1:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } bundle_t;

  bundle_t     txq[$];
  logic [31:0] expq[$];
  logic [31:0] got_dat[$];
  logic [31:0] got_addr[$];
  int          first_acc_tick, first_wr_tick, last_wr_tick, done_tick;
  int          checks = 0;
  int          failures = 0;

  function automatic bundle_t mk(input logic [1:0] fmt, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [12:0] imm,
                                 input logic last);
    bundle_t b;
    b.fmt = fmt; b.op = op; b.f3 = f3; b.f7 = f7; b.rd = rd;
    b.rs1 = rs1; b.rs2 = rs2; b.imm = imm; b.last = last;
    return b;
  endfunction

  function automatic bundle_t rand_bundle(input logic last);
    bundle_t b;
    b.fmt  = 2'($urandom);
    b.op   = 7'($urandom) | 7'h03;
    b.f3   = 3'($urandom);
    b.f7   = 7'($urandom);
    b.rd   = 5'($urandom);
    b.rs1  = 5'($urandom);
    b.rs2  = 5'($urandom);
    b.imm  = 13'($urandom);
    if (b.fmt == 2'b10) b.imm = b.imm & 13'h1FFE;
    b.last = last;
    return b;
  endfunction

  // Reference encoder: places each field at its bit offset using integer arithmetic.
  function automatic logic [31:0] model(input bundle_t b);
    int unsigned im, w;
    im = 32'(b.imm);
    w  = 32'(b.op) | (32'(b.f3) << 12) | (32'(b.rs1) << 15);
    case (b.fmt)
      2'b00: w = w | (32'(b.rd) << 7) | ((im % 4096) << 20);
      2'b01: w = w | (32'(b.rs2) << 20) | ((im % 32) << 7) | (((im / 32) % 128) << 25);
      2'b10: w = w | (32'(b.rs2) << 20) | (((im / 2) % 16) << 8) | (((im / 2048) % 2) << 7)
                   | (((im / 32) % 64) << 25) | (((im / 4096) % 2) << 31);
      default: w = w | (32'(b.rd) << 7) | (32'(b.rs2) << 20) | (32'(b.f7) << 25);
    endcase
    return w;
  endfunction

  task automatic drive(input bundle_t b);
    in_fmt = b.fmt; in_op = b.op; in_funct3 = b.f3; in_funct7 = b.f7; in_rd = b.rd;
    in_rs1 = b.rs1; in_rs2 = b.rs2; in_imm = b.imm; in_last = b.last;
  endtask

  task automatic new_prog();
    txq.delete(); expq.delete(); got_dat.delete(); got_addr.delete();
    first_acc_tick = -1; first_wr_tick = -1; last_wr_tick = -1; done_tick = -1;
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Feeds txq and records accepts/writes; comparisons are done by the callers.
  task automatic run_stream(input int rdy_pct, input int vld_pct, input int max_cyc,
                            output bit timed_out);
    int cyc = 0;
    timed_out = 1'b0;
    while (1) begin
      @(negedge clk);
      if (done) begin done_tick = tick; break; end
      if (cyc >= max_cyc) begin timed_out = 1'b1; break; end
      if (txq.size() > 0 && $urandom_range(99) < vld_pct) begin
        drive(txq[0]); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      mem_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (in_valid && in_ready) begin
        expq.push_back(model(txq[0]));
        void'(txq.pop_front());
        if (first_acc_tick < 0) first_acc_tick = tick;
      end
      if (mem_we && mem_ready) begin
        got_dat.push_back(mem_wdata);
        got_addr.push_back(mem_addr);
        if (first_wr_tick < 0) first_wr_tick = tick;
        last_wr_tick = tick;
      end
      cyc++;
    end
    in_valid = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks += 6;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    if (mem_addr !== BASE) begin failures++; $display("FAIL reset_mem_addr got=%h want=%h", mem_addr, BASE); end
    if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_i();
    bit to;
    new_prog();
    txq.push_back(mk(2'b00, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1));
    run_stream(100, 100, 50, to);
    checks += 6;
    if (to !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b want=0", to); end
    if (got_dat.size() !== 1) begin
      failures++; $display("FAIL single_count got=%0d want=1", got_dat.size());
    end else begin
      if (got_dat[0] !== 32'h00500093) begin failures++; $display("FAIL single_word got=%h want=00500093", got_dat[0]); end
      if (got_addr[0] !== BASE) begin failures++; $display("FAIL single_addr got=%h want=%h", got_addr[0], BASE); end
    end
    if (first_wr_tick !== first_acc_tick + 1) begin
      failures++; $display("FAIL single_latency got=%0d want=%0d", first_wr_tick, first_acc_tick + 1);
    end
    if (done_tick !== last_wr_tick + 1) begin
      failures++; $display("FAIL single_done_timing got=%0d want=%0d", done_tick, last_wr_tick + 1);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [31:0] want_w [3];
    want_w[0] = 32'h002081B3; want_w[1] = 32'h00202423; want_w[2] = 32'hFE208EE3;
    new_prog();
    txq.push_back(mk(2'b11, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0));
    txq.push_back(mk(2'b01, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd0, 5'd2, 13'd8, 1'b0));
    txq.push_back(mk(2'b10, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1));
    run_stream(100, 100, 50, to);
    checks += 2;
    if (to !== 1'b0) begin failures++; $display("FAIL b2b_timeout got=%b want=0", to); end
    if (got_dat.size() !== 3) begin
      failures++; $display("FAIL b2b_count got=%0d want=3", got_dat.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (got_dat[i] !== want_w[i]) begin failures++; $display("FAIL b2b_word%0d got=%h want=%h", i, got_dat[i], want_w[i]); end
        if (got_addr[i] !== BASE + 32'(4 * i)) begin failures++; $display("FAIL b2b_addr%0d got=%h want=%h", i, got_addr[i], BASE + 32'(4 * i)); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int accepts = 0;
    int unstable = 0;
    bit seen = 0;
    logic [31:0] a0, d0;
    new_prog();
    for (int i = 0; i <= DEPTH; i++) txq.push_back(rand_bundle(i == DEPTH));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      in_valid = (txq.size() > 0);
      if (in_valid) drive(txq[0]);
      #1;
      if (mem_we) begin
        if (!seen) begin seen = 1; a0 = mem_addr; d0 = mem_wdata; end
        else if (mem_addr !== a0 || mem_wdata !== d0) unstable++;
      end
      if (in_valid && in_ready) begin
        accepts++; expq.push_back(model(txq[0])); void'(txq.pop_front());
      end
    end
    checks += 4;
    if (accepts !== DEPTH) begin failures++; $display("FAIL bp_accepts got=%0d want=%0d", accepts, DEPTH); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    if (unstable !== 0) begin failures++; $display("FAIL bp_stable got=%0d changes want=0", unstable); end
    if (!seen || d0 !== expq[0] || a0 !== BASE) begin
      failures++; $display("FAIL bp_head got=%h@%h want=%h@%h", d0, a0, expq[0], BASE);
    end
    run_stream(100, 100, 50, to);
    checks += 2;
    if (to !== 1'b0) begin failures++; $display("FAIL bp_timeout got=%b want=0", to); end
    if (got_dat.size() !== DEPTH + 1) begin
      failures++; $display("FAIL bp_count got=%0d want=%0d", got_dat.size(), DEPTH + 1);
    end else begin
      for (int i = 0; i <= DEPTH; i++) begin
        checks++;
        if (got_dat[i] !== expq[i] || got_addr[i] !== BASE + 32'(4 * i)) begin
          failures++; $display("FAIL bp_write%0d got=%h@%h want=%h@%h", i, got_dat[i], got_addr[i], expq[i], BASE + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int writes = 0;
    int guard = 0;
    new_prog();
    txq.push_back(rand_bundle(1'b0));
    txq.push_back(rand_bundle(1'b1));
    while (txq.size() > 0 && guard < 10) begin
      @(negedge clk);
      mem_ready = 1'b0; in_valid = 1'b1; drive(txq[0]);
      #1;
      if (in_ready) void'(txq.pop_front());
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks += 1;
    if (mem_we !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_pre_drain got=we%b/rdy%b want=we1/rdy0", mem_we, in_ready);
    end
    rst = 1'b0;
    #1;
    checks += 4;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mid_we got=%b want=0", mem_we); end
    if (mem_addr !== BASE) begin failures++; $display("FAIL rst_mid_addr got=%h want=%h", mem_addr, BASE); end
    if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mid_wdata got=%h want=0", mem_wdata); end
    if (in_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL rst_mid_ctl got=rdy%b/done%b want=rdy1/done0", in_ready, done); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      if (mem_we) writes++;
    end
    mem_ready = 1'b0;
    checks++;
    if (writes !== 0) begin failures++; $display("FAIL rst_no_writes got=%0d want=0", writes); end
  endtask

  task automatic test_clr_restart();
    bit to;
    bundle_t b;
    new_prog();
    txq.push_back(rand_bundle(1'b0));
    txq.push_back(rand_bundle(1'b1));
    run_stream(100, 100, 50, to);
    checks += 1;
    if (to !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL clr_pre_done got=to%b/done%b/rdy%b want=to0/done1/rdy0", to, done, in_ready);
    end
    new_prog();
    #1;
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL clr_done got=%b want=0", done); end
    if (mem_addr !== BASE) begin failures++; $display("FAIL clr_addr got=%h want=%h", mem_addr, BASE); end
    // An accept in the same cycle as clr must be discarded.
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; drive(rand_bundle(1'b0));
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL clr_vs_accept got=we%b/rdy%b want=we0/rdy1", mem_we, in_ready);
    end
    b = rand_bundle(1'b1);
    b.fmt = 2'b00;
    txq.push_back(b);
    run_stream(100, 100, 50, to);
    checks++;
    if (to !== 1'b0 || got_dat.size() !== 1 || got_dat[0] !== model(b) || got_addr[0] !== BASE) begin
      failures++; $display("FAIL clr_reload got=%0d writes first=%h want=1 writes %h@%h", got_dat.size(), (got_dat.size() > 0) ? got_dat[0] : 32'h0, model(b), BASE);
    end
  endtask

  task automatic test_random();
    bit to;
    int n;
    n = 20;
    new_prog();
    for (int i = 0; i < n; i++) txq.push_back(rand_bundle(i == n - 1));
    run_stream(60, 70, 400, to);
    checks += 4;
    if (to !== 1'b0) begin failures++; $display("FAIL rand_timeout got=%b want=0", to); end
    if (done !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      failures++; $display("FAIL rand_done_state got=done%b/rdy%b/we%b want=1/0/0", done, in_ready, mem_we);
    end
    if (err !== 1'b0) begin failures++; $display("FAIL rand_err got=%b want=0", err); end
    if (got_dat.size() !== n) begin
      failures++; $display("FAIL rand_count got=%0d want=%0d", got_dat.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (got_dat[i] !== expq[i] || got_addr[i] !== BASE + 32'(4 * i)) begin
          failures++; $display("FAIL rand_write%0d got=%h@%h want=%h@%h", i, got_dat[i], got_addr[i], expq[i], BASE + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_enc_check();
    bit to;
    bundle_t b, b_even;
    logic want_err;
`ifdef ENC_CHECK_EN
    want_err = 1'b1;
`else
    want_err = 1'b0;
`endif
    new_prog();
    b = mk(2'b10, 7'b1100011, 3'd1, 7'd0, 5'd0, 5'd3, 5'd4, 13'h0003, 1'b1);
    b_even = b;
    b_even.imm = 13'h0002;
    txq.push_back(b);
    run_stream(100, 100, 50, to);
    checks += 3;
    if (to !== 1'b0 || got_dat.size() !== 1) begin
      failures++; $display("FAIL chk_count got=%0d want=1", got_dat.size());
    end else if (got_dat[0] !== model(b_even)) begin
      failures++; $display("FAIL chk_word got=%h want=%h", got_dat[0], model(b_even));
    end
    if (err !== want_err) begin failures++; $display("FAIL chk_err_sticky got=%b want=%b", err, want_err); end
    new_prog();
    #1;
    if (err !== 1'b0) begin failures++; $display("FAIL chk_err_clr got=%b want=0", err); end
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    drive(mk(2'b00, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0));
    test_reset();
    test_single_i();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_drain();
    test_clr_restart();
    test_random();
    test_enc_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
